// File: rtl/rs_age_multi_cdb.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_multi_cdb
// Purpose  : Reservation station for ALU ops. Holds up to RS_DEPTH decoded
//            instructions, captures missing operands from CDB_PORTS parallel
//            result buses, and dispatches the oldest ready entry into a
//            registered ALU-issue stage with valid/ready handshaking.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in / rst_in          clock, asynchronous active-low reset
//   rdy_in                   global enable, low freezes every register
//   flush_in                 synchronous clear of all entries and dispatch
//   issue_valid/issue_ready  decoder handshake (ready = a free entry exists)
//   op_type_in/op_in/op_add_in, vj_in/vk_in, dep_*_in, q*_in, rd_rob_in
//                            fields of the incoming instruction
//   cdb_valid/cdb_rob/cdb_value  packed result buses, bus p in slice p
//   alu_valid/alu_ready      dispatch register handshake
//   alu_op_type/alu_op/alu_add/alu_vj/alu_vk/alu_rob  dispatched fields
//   count                    number of occupied entries
// ============================================================================
module rs_age_multi_cdb #(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_BIT   = 4,
  parameter int CDB_PORTS = 2,
  parameter int XLEN      = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [6:0]                    op_type_in,
  input  logic [2:0]                    op_in,
  input  logic                          op_add_in,
  input  logic [XLEN-1:0]               vj_in,
  input  logic [XLEN-1:0]               vk_in,
  input  logic                          dep_j_in,
  input  logic                          dep_k_in,
  input  logic [ROB_BIT-1:0]            qj_in,
  input  logic [ROB_BIT-1:0]            qk_in,
  input  logic [ROB_BIT-1:0]            rd_rob_in,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_BIT-1:0]  cdb_rob,
  input  logic [CDB_PORTS*XLEN-1:0]     cdb_value,
  output logic                          alu_valid,
  input  logic                          alu_ready,
  output logic [6:0]                    alu_op_type,
  output logic [2:0]                    alu_op,
  output logic                          alu_add,
  output logic [XLEN-1:0]               alu_vj,
  output logic [XLEN-1:0]               alu_vk,
  output logic [ROB_BIT-1:0]            alu_rob,
  output logic [$clog2(RS_DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(RS_DEPTH+1);

  // Returns {hit, value}. Scanning from the highest bus down lets the lowest
  // matching bus overwrite the result, so bus 0 has priority.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_BIT-1:0]           tag,
    input logic [CDB_PORTS-1:0]         bus_valid,
    input logic [CDB_PORTS*ROB_BIT-1:0] bus_rob,
    input logic [CDB_PORTS*XLEN-1:0]    bus_value
  );
    logic [XLEN:0] res;
    res = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (bus_valid[p] && (bus_rob[p*ROB_BIT +: ROB_BIT] == tag)) begin
        res = {1'b1, bus_value[p*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  // Entry storage
  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] dep_j;
  logic [RS_DEPTH-1:0] dep_k;
  logic [ROB_BIT-1:0]  q_j      [RS_DEPTH];
  logic [ROB_BIT-1:0]  q_k      [RS_DEPTH];
  logic [XLEN-1:0]     v_j      [RS_DEPTH];
  logic [XLEN-1:0]     v_k      [RS_DEPTH];
  logic [6:0]          e_optype [RS_DEPTH];
  logic [2:0]          e_op     [RS_DEPTH];
  logic [RS_DEPTH-1:0] e_add;
  logic [ROB_BIT-1:0]  e_rob    [RS_DEPTH];
  // older[i][j] = 1 means entry i was allocated before entry j
  logic [RS_DEPTH-1:0] older    [RS_DEPTH];

  // Combinational control
  logic [RS_DEPTH-1:0] free_oh;
  logic [RS_DEPTH-1:0] alloc_oh;
  logic                alloc;
  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] sel_oh;
  logic [RS_DEPTH-1:0] take;
  logic                disp_fire;
  logic [RS_DEPTH-1:0] wake_j_hit;
  logic [RS_DEPTH-1:0] wake_k_hit;
  logic [XLEN-1:0]     wake_j_val [RS_DEPTH];
  logic [XLEN-1:0]     wake_k_val [RS_DEPTH];
  logic                in_j_hit;
  logic                in_k_hit;
  logic [XLEN-1:0]     in_j_val;
  logic [XLEN-1:0]     in_k_val;
  logic [6:0]          d_optype;
  logic [2:0]          d_op;
  logic                d_add;
  logic [XLEN-1:0]     d_vj;
  logic [XLEN-1:0]     d_vk;
  logic [ROB_BIT-1:0]  d_rob;

  // Credit comes from registered occupancy only; a same-cycle dispatch does
  // not make room for an issue in that cycle.
  assign issue_ready = (count < CNT_W'(RS_DEPTH));
  assign alloc       = issue_valid && issue_ready;
  // Lowest clear bit of busy, isolated as a one-hot vector
  assign free_oh     = ~busy & (busy + RS_DEPTH'(1));
  assign alloc_oh    = alloc ? free_oh : '0;

  assign ready       = busy & ~dep_j & ~dep_k;
  assign disp_fire   = (!alu_valid || alu_ready) && (|ready);
  assign take        = disp_fire ? sel_oh : '0;

  assign {in_j_hit, in_j_val} = cdb_lookup(qj_in, cdb_valid, cdb_rob, cdb_value);
  assign {in_k_hit, in_k_val} = cdb_lookup(qk_in, cdb_valid, cdb_rob, cdb_value);

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      {wake_j_hit[i], wake_j_val[i]} = cdb_lookup(q_j[i], cdb_valid, cdb_rob, cdb_value);
      {wake_k_hit[i], wake_k_val[i]} = cdb_lookup(q_k[i], cdb_valid, cdb_rob, cdb_value);
    end
  end

  // Oldest-ready selection: entry i wins when, for every other ready entry j,
  // i is older than j. The matrix is a strict total order over busy entries,
  // so at most one bit of sel_oh is set.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      sel_oh[i] = ready[i] && (&(older[i] | ~ready | (RS_DEPTH'(1) << i)));
    end
  end

  // One-hot AND-OR mux of the selected entry
  always_comb begin
    d_optype = '0;
    d_op     = '0;
    d_add    = 1'b0;
    d_vj     = '0;
    d_vk     = '0;
    d_rob    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      d_optype = d_optype | ({7{sel_oh[i]}} & e_optype[i]);
      d_op     = d_op     | ({3{sel_oh[i]}} & e_op[i]);
      d_add    = d_add    | (sel_oh[i] & e_add[i]);
      d_vj     = d_vj     | ({XLEN{sel_oh[i]}} & v_j[i]);
      d_vk     = d_vk     | ({XLEN{sel_oh[i]}} & v_k[i]);
      d_rob    = d_rob    | ({ROB_BIT{sel_oh[i]}} & e_rob[i]);
    end
  end

  // Entry array and age matrix
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy  <= '0;
      dep_j <= '0;
      dep_k <= '0;
      e_add <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        q_j[i]      <= '0;
        q_k[i]      <= '0;
        v_j[i]      <= '0;
        v_k[i]      <= '0;
        e_optype[i] <= '0;
        e_op[i]     <= '0;
        e_rob[i]    <= '0;
        older[i]    <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy  <= '0;
        dep_j <= '0;
        dep_k <= '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
          older[i] <= '0;
        end
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          // take and alloc_oh are disjoint: one hits a busy slot, the other a free one
          if (take[i]) begin
            busy[i] <= 1'b0;
          end else if (alloc_oh[i]) begin
            busy[i]     <= 1'b1;
            e_optype[i] <= op_type_in;
            e_op[i]     <= op_in;
            e_add[i]    <= op_add_in;
            e_rob[i]    <= rd_rob_in;
            q_j[i]      <= qj_in;
            q_k[i]      <= qk_in;
            dep_j[i]    <= dep_j_in && !in_j_hit;
            dep_k[i]    <= dep_k_in && !in_k_hit;
            v_j[i]      <= (dep_j_in && in_j_hit) ? in_j_val : vj_in;
            v_k[i]      <= (dep_k_in && in_k_hit) ? in_k_val : vk_in;
          end else if (busy[i]) begin
            // Only still-pending flags are matched, so a stale tag cannot
            // overwrite an operand that already arrived.
            if (dep_j[i] && wake_j_hit[i]) begin
              v_j[i]   <= wake_j_val[i];
              dep_j[i] <= 1'b0;
            end
            if (dep_k[i] && wake_k_hit[i]) begin
              v_k[i]   <= wake_k_val[i];
              dep_k[i] <= 1'b0;
            end
          end
          // New entry: its row is cleared (older than nobody) and its column
          // is set for every currently busy entry (they are all older).
          if (alloc_oh[i]) begin
            older[i] <= '0;
          end else begin
            older[i] <= (older[i] & ~alloc_oh) | (busy[i] ? alloc_oh : '0);
          end
        end
      end
    end
  end

  // Dispatch register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_valid   <= 1'b0;
      alu_op_type <= '0;
      alu_op      <= '0;
      alu_add     <= 1'b0;
      alu_vj      <= '0;
      alu_vk      <= '0;
      alu_rob     <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        alu_valid <= 1'b0;
      end else if (disp_fire) begin
        alu_valid   <= 1'b1;
        alu_op_type <= d_optype;
        alu_op      <= d_op;
        alu_add     <= d_add;
        alu_vj      <= d_vj;
        alu_vk      <= d_vk;
        alu_rob     <= d_rob;
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(alloc) - CNT_W'(disp_fire);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_age_multi_cdb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_age_multi_cdb
// Purpose  : Directed self-checking bench for rs_age_multi_cdb with the
//            default parameters (16 entries, 4-bit tags, 2 CDB buses, XLEN 32).
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_age_multi_cdb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  op_type_in;
  logic [2:0]  op_in;
  logic        op_add_in;
  logic [31:0] vj_in;
  logic [31:0] vk_in;
  logic        dep_j_in;
  logic        dep_k_in;
  logic [3:0]  qj_in;
  logic [3:0]  qk_in;
  logic [3:0]  rd_rob_in;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob;
  logic [63:0] cdb_value;
  logic        alu_valid;
  logic        alu_ready;
  logic [6:0]  alu_op_type;
  logic [2:0]  alu_op;
  logic        alu_add;
  logic [31:0] alu_vj;
  logic [31:0] alu_vk;
  logic [3:0]  alu_rob;
  logic [4:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  rs_age_multi_cdb dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .op_type_in  (op_type_in),
    .op_in       (op_in),
    .op_add_in   (op_add_in),
    .vj_in       (vj_in),
    .vk_in       (vk_in),
    .dep_j_in    (dep_j_in),
    .dep_k_in    (dep_k_in),
    .qj_in       (qj_in),
    .qk_in       (qk_in),
    .rd_rob_in   (rd_rob_in),
    .cdb_valid   (cdb_valid),
    .cdb_rob     (cdb_rob),
    .cdb_value   (cdb_value),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_op_type (alu_op_type),
    .alu_op      (alu_op),
    .alu_add     (alu_add),
    .alu_vj      (alu_vj),
    .alu_vk      (alu_vk),
    .alu_rob     (alu_rob),
    .count       (count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_op(input logic dj, input logic [3:0] qj, input logic [31:0] vj,
                          input logic dk, input logic [3:0] qk, input logic [31:0] vk,
                          input logic [3:0] rob);
    issue_valid = 1'b1;
    dep_j_in    = dj;
    qj_in       = qj;
    vj_in       = vj;
    dep_k_in    = dk;
    qk_in       = qk;
    vk_in       = vk;
    rd_rob_in   = rob;
  endtask

  task automatic set_cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[p]         = 1'b1;
    cdb_rob[p*4 +: 4]    = tag;
    cdb_value[p*32 +: 32] = val;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0;
    cdb_rob   = '0;
    cdb_value = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    flush_in    = 1'b0;
    issue_valid = 1'b0;
    op_type_in  = 7'h33;
    op_in       = 3'd0;
    op_add_in   = 1'b0;
    vj_in       = '0;
    vk_in       = '0;
    dep_j_in    = 1'b0;
    dep_k_in    = 1'b0;
    qj_in       = '0;
    qk_in       = '0;
    rd_rob_in   = '0;
    alu_ready   = 1'b0;
    clear_cdb();
    tick();
    tick();
    check("reset_count", count, 0);
    check("reset_alu_valid", alu_valid, 0);
    check("reset_issue_ready", issue_ready, 1);
    check("reset_alu_vj", alu_vj, 0);
    rst_in = 1'b1;
    tick();

    // ---- 1: asynchronous reset in the middle of operation ----
    alu_ready = 1'b0;
    drive_op(0, 0, 32'h10, 0, 0, 32'h20, 4'd1); tick();
    drive_op(1, 4'd7, 0, 0, 0, 0, 4'd2); tick();
    drive_op(1, 4'd7, 0, 0, 0, 0, 4'd3); tick();
    drive_op(1, 4'd7, 0, 0, 0, 0, 4'd4); tick();
    issue_valid = 1'b0;
    check("t1_count_before", count, 3);
    check("t1_valid_before", alu_valid, 1);
    check("t1_rob_before", alu_rob, 1);
    #2 rst_in = 1'b0;
    #1;
    check("t1_count_async", count, 0);
    check("t1_valid_async", alu_valid, 0);
    check("t1_vj_async", alu_vj, 0);
    tick();
    rst_in = 1'b1;
    tick();

    // ---- 2: age order B, C, then A after CDB wakeup on bus 1 ----
    alu_ready = 1'b1;
    drive_op(1, 4'd5, 0, 0, 0, 32'h1, 4'd1); tick();
    drive_op(0, 0, 32'h22, 0, 0, 32'h2, 4'd2); tick();
    drive_op(0, 0, 32'h33, 0, 0, 32'h3, 4'd3); tick();
    issue_valid = 1'b0;
    check("t2_first_valid", alu_valid, 1);
    check("t2_first_rob", alu_rob, 2);
    check("t2_first_vj", alu_vj, 32'h22);
    tick();
    check("t2_second_rob", alu_rob, 3);
    check("t2_second_vj", alu_vj, 32'h33);
    check("t2_count_after_c", count, 1);
    set_cdb(1, 4'd5, 32'h11);
    tick();
    clear_cdb();
    check("t2_wake_cycle_valid", alu_valid, 0);
    check("t2_wake_cycle_count", count, 1);
    tick();
    check("t2_third_valid", alu_valid, 1);
    check("t2_third_rob", alu_rob, 1);
    check("t2_third_vj", alu_vj, 32'h11);
    check("t2_third_vk", alu_vk, 32'h1);
    check("t2_count_empty", count, 0);
    tick();
    check("t2_drained", alu_valid, 0);

    // ---- 3: back-pressure; younger entry sits at a lower index ----
    alu_ready = 1'b0;
    drive_op(0, 0, 32'h44, 0, 0, 0, 4'd4); tick();
    drive_op(0, 0, 32'h55, 0, 0, 0, 4'd5); tick();
    drive_op(0, 0, 32'h66, 0, 0, 0, 4'd6); tick();
    issue_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t3_hold_valid", alu_valid, 1);
      check("t3_hold_rob", alu_rob, 4);
      check("t3_hold_vj", alu_vj, 32'h44);
      check("t3_hold_count", count, 2);
      tick();
    end
    alu_ready = 1'b1;
    tick();
    check("t3_rel1_rob", alu_rob, 5);
    check("t3_rel1_count", count, 1);
    tick();
    check("t3_rel2_rob", alu_rob, 6);
    check("t3_rel2_valid", alu_valid, 1);
    check("t3_rel2_count", count, 0);
    tick();
    check("t3_drained", alu_valid, 0);

    // ---- 4: fill all 16 entries, reject the 17th, wake one ----
    for (int i = 0; i < 16; i++) begin
      drive_op(1, 4'(i), 0, 0, 0, 0, 4'(i));
      tick();
    end
    issue_valid = 1'b0;
    check("t4_full_count", count, 16);
    check("t4_full_ready", issue_ready, 0);
    drive_op(0, 0, 32'hEE, 0, 0, 0, 4'hE);
    tick();
    issue_valid = 1'b0;
    check("t4_ignored_count", count, 16);
    check("t4_ignored_valid", alu_valid, 0);
    set_cdb(0, 4'd7, 32'h77);
    tick();
    clear_cdb();
    check("t4_wake_count", count, 16);
    check("t4_wake_ready", issue_ready, 0);
    tick();
    check("t4_disp_valid", alu_valid, 1);
    check("t4_disp_rob", alu_rob, 7);
    check("t4_disp_vj", alu_vj, 32'h77);
    check("t4_disp_count", count, 15);
    check("t4_disp_ready", issue_ready, 1);

    // ---- 6: rdy_in freeze, then flush with a competing issue ----
    rdy_in = 1'b0;
    drive_op(0, 0, 32'h99, 0, 0, 0, 4'd9);
    set_cdb(0, 4'd8, 32'h88);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_frozen_count", count, 15);
      check("t6_frozen_valid", alu_valid, 1);
      check("t6_frozen_rob", alu_rob, 7);
    end
    clear_cdb();
    rdy_in   = 1'b1;
    flush_in = 1'b1;
    tick();
    flush_in    = 1'b0;
    issue_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_valid", alu_valid, 0);
    check("t6_flush_ready", issue_ready, 1);
    tick();
    check("t6_post_count", count, 0);
    check("t6_post_valid", alu_valid, 0);

    // ---- 5: issue-time bypass from both buses, then bus priority ----
    op_type_in = 7'h13;
    op_in      = 3'd5;
    op_add_in  = 1'b1;
    drive_op(1, 4'd2, 32'hDEAD, 1, 4'd3, 32'hBEEF, 4'd9);
    set_cdb(0, 4'd2, 32'hA);
    set_cdb(1, 4'd3, 32'hB);
    tick();
    issue_valid = 1'b0;
    clear_cdb();
    op_type_in = 7'h33;
    op_in      = 3'd0;
    op_add_in  = 1'b0;
    tick();
    check("t5_valid", alu_valid, 1);
    check("t5_vj", alu_vj, 32'hA);
    check("t5_vk", alu_vk, 32'hB);
    check("t5_rob", alu_rob, 9);
    check("t5_op_type", alu_op_type, 7'h13);
    check("t5_op", alu_op, 3'd5);
    check("t5_add", alu_add, 1);
    drive_op(1, 4'd4, 32'hDEAD, 0, 0, 32'h5, 4'hC);
    tick();
    issue_valid = 1'b0;
    set_cdb(0, 4'd4, 32'h40);
    set_cdb(1, 4'd4, 32'h41);
    tick();
    clear_cdb();
    tick();
    check("t5_prio_valid", alu_valid, 1);
    check("t5_prio_rob", alu_rob, 4'hC);
    check("t5_prio_vj", alu_vj, 32'h40);
    check("t5_prio_vk", alu_vk, 32'h5);
    tick();
    check("t5_final_valid", alu_valid, 0);
    check("t5_final_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
